bus_grant_arbiter: RTL and testbench
====================================

// Module: bus_grant_arbiter
// PURPOSE
//   Round-robin arbiter for the shared CPU bus. Collects up to N source requests
//   and drives a registered one-hot grant word straight into the 32-to-5 bus
//   encoder's i input, whose 5-bit select drives the bus mux. Guarantees grant
//   is all-zero or exactly one-hot. Enforces an optional hold timeout.
// PARAMETERS
//   N        32   number of request/grant lines; must equal the encoder input width
//   TIMEOUT  16   max consecutive GRANT cycles per owner; 0 = no timeout
// PORTS
//   clk      in   1   rising-edge clock, single clock domain
//   clr      in   1   synchronous, active-high reset
//   req      in   N   request lines, bit k = source k; level, held until served
//   release  in   1   current owner is finished; sampled only in GRANT
//   grant    out  N   registered one-hot grant, or all-zero when idle
//   busy     out  1   registered; 1 while state == GRANT
//   timeout  out  1   registered one-cycle pulse: owner forcibly revoked
// BEHAVIOUR
//   Reset: clr is sampled at posedge clk and overrides every other input. The
//     next edge gives grant=0, busy=0, timeout=0, ptr=0, cnt=0, state=IDLE.
//     In any state, a clr mid-grant drops grant to 0 on that same edge.
//   State: IDLE, GRANT, HANDOFF. Internal ptr is a $clog2(N)-bit wrapping pointer.
//     cnt is a $clog2(TIMEOUT+1)-bit counter.
//   IDLE: if req != 0, choose the first set bit scanning upward from ptr and
//     wrapping N-1 -> 0. That bit is the owner. On the same edge: grant=onehot(owner),
//     busy=1, cnt=0, state=GRANT. If req == 0, stay in IDLE with grant=0.
//     Latency from req rising (in IDLE) to grant visible is 1 clock.
//   GRANT: the revoke condition is:
//       release == 1
//     OR req[owner] == 0
//     OR (TIMEOUT != 0 AND cnt == TIMEOUT-1).
//     When the condition is false: cnt increments and grant is held unchanged.
//     When it is true: on the next edge grant=0, busy=0, ptr=(owner+1) mod N,
//       cnt=0, state=HANDOFF.
//     timeout=1 on that edge only if the timeout term is the sole cause.
//     If release or a req drop coincides with expiry, release wins and timeout stays 0.
//   HANDOFF: exactly one dead cycle with grant=0. This gives the downstream
//     encoder its idle code before the next owner drives. timeout returns to 0.
//     Next state is always IDLE; no arbitration happens in HANDOFF.
//   Ownership: an owner holds the bus for at most TIMEOUT cycles.
//     The minimum gap between two owners is 2 cycles (HANDOFF plus the IDLE
//     arbitration edge).
//   Changes to req bits other than the owner's are ignored during GRANT.
//   Arithmetic: ptr wraps modulo N (owner N-1 -> ptr 0). cnt saturates,
//     never wraps.
//   grant is never multi-hot. The bench asserts $onehot0(grant) every cycle.
// TESTING
//   1. clr=1 for 2 cycles then req=0 for 20 cycles -> grant=0, busy=0,
//      timeout=0 throughout.
//   2. After reset, req=32'h0000_0014 -> grant=32'h0000_0004 one edge later.
//      Pulse release -> grant=0 for one cycle (HANDOFF), then IDLE, then
//      grant=32'h0000_0010.
//   3. Serve bit 31 (ptr wraps to 0), then req=32'h8000_0001 -> grant=32'h0000_0001
//      (wrap-around fairness). Next round grants 32'h8000_0000.
//   4. TIMEOUT=8, req=32'h0000_0020 held, release=0 -> grant=32'h20 for exactly
//      8 cycles. Then timeout=1 for 1 cycle with grant=0, then IDLE, then
//      re-grant 32'h20.
//   5. TIMEOUT=8, release=1 on cycle 8 of ownership -> revoke with timeout=0.
//      Also: req[owner] drops mid-GRANT -> revoke on the next edge.
//   6. clr=1 while grant=32'h0000_0100 -> next edge grant=0, busy=0.
//      With req=32'h0000_0101 after release of clr -> grant=32'h0000_0001
//      (ptr reset to 0).

Source files
------------

// File: rtl/bus_grant_arbiter_if.sv
// Bus-grant interface: bundles the request/grant handshake of the shared CPU bus.
//   req      N   request lines, bit k = source k (level, held until served)
//   rel      1   current owner is finished ("release" is a reserved word)
//   grant    N   one-hot grant word, or all-zero when idle
//   busy     1   high while a source owns the bus
//   timeout  1   one-cycle pulse when the owner was forcibly revoked
// master: the arbiter side; slave: the requesting/observing side.
interface bus_grant_arbiter_if #(
   parameter int unsigned N = 32
);
   logic [N-1:0] req;
   logic         rel;
   logic [N-1:0] grant;
   logic         busy;
   logic         timeout;

   modport master (
      input  req,
      input  rel,
      output grant,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      output rel,
      input  grant,
      input  busy,
      input  timeout
   );
endinterface

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter for the shared CPU bus. Produces a registered grant word
// that is either all-zero or exactly one-hot, suitable for feeding the bus
// encoder directly. Each ownership is followed by one dead HANDOFF cycle, and
// an optional timeout revokes an owner after TIMEOUT grant cycles.
//   clk   rising-edge clock
//   clr   synchronous active-high reset, overrides all other inputs
//   bus   bus_grant_arbiter_if.master (req, rel in; grant, busy, timeout out)
// Parameters: N request lines; TIMEOUT max grant cycles per owner (0 = none).
module bus_grant_arbiter #(
   parameter int unsigned N       = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                clr,
   bus_grant_arbiter_if.master bus
);
   localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;
   logic          found;
   logic          expire;
   logic          revoke;
   int unsigned   scan_idx;

   // Round-robin scan: first set request at or above ptr, wrapping N-1 -> 0.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = 0;
      for (int unsigned i = 0; i < N; i++) begin
         scan_idx = 32'(ptr_q) + i;
         if (scan_idx >= N) scan_idx = scan_idx - N;
         if (!found && bus.req[PW'(scan_idx)]) begin
            found = 1'b1;
            pick  = PW'(scan_idx);
         end
      end
   end

   assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TLIM));
   assign revoke = bus.rel || !bus.req[owner_q] || expire;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (found) begin
               owner_d       = pick;
               grant_d[pick] = 1'b1;
               busy_d        = 1'b1;
               cnt_d         = '0;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (revoke) begin
               grant_d   = '0;
               busy_d    = 1'b0;
               cnt_d     = '0;
               ptr_d     = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
               // Flag a timeout only when expiry alone caused the revoke.
               timeout_d = expire && !bus.rel && bus.req[owner_q];
               state_d   = HANDOFF;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HANDOFF: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed testbench for bus_grant_arbiter (N=32, TIMEOUT=8). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_bus_grant_arbiter;
   localparam int unsigned N       = 32;
   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        clr;
   int unsigned total = 0;
   int unsigned bad   = 0;

   bus_grant_arbiter_if #(.N(N)) bus_if ();

   bus_grant_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [31:0] g, input logic b, input logic t);
      check_val({tag, ".grant"},   bus_if.grant,          g);
      check_val({tag, ".busy"},    32'(bus_if.busy),      32'(b));
      check_val({tag, ".timeout"}, 32'(bus_if.timeout),   32'(t));
   endtask

   // grant must never be multi-hot
   always @(negedge clk) check_val("onehot0", 32'($onehot0(bus_if.grant)), 32'd1);

   initial begin
      clr         = 1'b1;
      bus_if.req  = '0;
      bus_if.rel  = 1'b0;
      tick();
      tick();
      expect_out("reset", 32'h0, 1'b0, 1'b0);
      clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_out("idle", 32'h0, 1'b0, 1'b0);
      end

      // basic grant, release, handoff; ptr moves past bit 2
      bus_if.req = 32'h0000_0014;
      tick(); expect_out("t2.first", 32'h0000_0004, 1'b1, 1'b0);
      bus_if.rel = 1'b1;
      tick(); expect_out("t2.handoff", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t2.idle", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t2.next", 32'h0000_0010, 1'b1, 1'b0);
      bus_if.rel = 1'b1;
      bus_if.req = '0;
      tick(); expect_out("t2.rel", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t2.back", 32'h0, 1'b0, 1'b0);

      // wrap-around fairness
      bus_if.req = 32'h8000_0000;
      tick(); expect_out("t3.b31", 32'h8000_0000, 1'b1, 1'b0);
      bus_if.rel = 1'b1;
      bus_if.req = 32'h8000_0001;
      tick(); expect_out("t3.handoff", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t3.idle", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t3.wrap", 32'h0000_0001, 1'b1, 1'b0);
      bus_if.rel = 1'b1;
      tick(); expect_out("t3.handoff2", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t3.idle2", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t3.b31again", 32'h8000_0000, 1'b1, 1'b0);
      bus_if.rel = 1'b1;
      bus_if.req = '0;
      tick(); expect_out("t3.rel", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t3.back", 32'h0, 1'b0, 1'b0);

      // timeout: exactly 8 grant cycles, then a timeout pulse
      bus_if.req = 32'h0000_0020;
      for (int i = 0; i < 8; i++) begin
         tick(); expect_out("t4.hold", 32'h0000_0020, 1'b1, 1'b0);
      end
      tick(); expect_out("t4.expire", 32'h0, 1'b0, 1'b1);
      tick(); expect_out("t4.idle", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t4.regrant", 32'h0000_0020, 1'b1, 1'b0);

      // other requests ignored mid-grant; release on expiry cycle wins
      bus_if.req = 32'h0000_0060;
      for (int i = 0; i < 7; i++) begin
         tick(); expect_out("t5.hold", 32'h0000_0020, 1'b1, 1'b0);
      end
      bus_if.rel = 1'b1;
      bus_if.req = 32'h0000_0020;
      tick(); expect_out("t5.relwins", 32'h0, 1'b0, 1'b0);
      bus_if.rel = 1'b0;
      tick(); expect_out("t5.idle", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t5.grant", 32'h0000_0020, 1'b1, 1'b0);
      tick(); expect_out("t5.hold2", 32'h0000_0020, 1'b1, 1'b0);
      bus_if.req = '0;
      tick(); expect_out("t5.reqdrop", 32'h0, 1'b0, 1'b0);
      tick(); expect_out("t5.back", 32'h0, 1'b0, 1'b0);

      // clear mid-grant resets grant and ptr
      bus_if.req = 32'h0000_0100;
      tick(); expect_out("t6.grant", 32'h0000_0100, 1'b1, 1'b0);
      clr = 1'b1;
      tick(); expect_out("t6.clr", 32'h0, 1'b0, 1'b0);
      clr        = 1'b0;
      bus_if.req = 32'h0000_0101;
      tick(); expect_out("t6.ptr0", 32'h0000_0001, 1'b1, 1'b0);

      bus_if.req = '0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
